// File: rtl/linebuffer_2x2_ctrl_pkg.sv
// Shared types and constants for the 2x2 line-buffer frame sequencer.
package lb_ctrl_pkg;

   localparam logic [2:0] SEL_MAX = 3'd5;

   // Width code -> frame edge length (frames are square).
   localparam logic [5:0][7:0] WIDTH_TBL = {8'd224, 8'd112, 8'd56, 8'd28, 8'd14, 8'd8};

   typedef enum logic [1:0] {IDLE, READ, FLUSH} state_t;

   typedef struct packed {
      logic       valid;
      logic [7:0] row;
      logic [7:0] col;
   } tag_t;

   function automatic logic [7:0] width_of(input logic [2:0] sel);
      return (sel > SEL_MAX) ? 8'd0 : WIDTH_TBL[sel];
   endfunction

endpackage

// File: rtl/linebuffer_2x2_ctrl_if.sv
// Memory, line-buffer and pooled-window signals of the frame sequencer.
interface linebuffer_2x2_ctrl_if #(parameter int ADDR_W = 16);
   logic              start;
   logic [2:0]        cfg_sel;
   logic              busy;
   logic              done;
   logic              err;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [3:0]        rd_data;
   logic [2:0]        lb_sel;
   logic [3:0]        lb_pix;
   logic [15:0]       lb_win;
   logic              win_valid;
   logic [15:0]       win_data;
   logic [6:0]        win_row;
   logic [6:0]        win_col;

   modport master (
      input  start, cfg_sel, rd_data, lb_win,
      output busy, done, err, rd_en, rd_addr, lb_sel, lb_pix,
             win_valid, win_data, win_row, win_col
   );

   modport slave (
      output start, cfg_sel, rd_data, lb_win,
      input  busy, done, err, rd_en, rd_addr, lb_sel, lb_pix,
             win_valid, win_data, win_row, win_col
   );
endinterface

// File: rtl/linebuffer_2x2_ctrl_tag_pipe.sv
// Delay line carrying {valid,row,col} of each issued read alongside its pixel.
module lb_tag_pipe
   import lb_ctrl_pkg::*;
#(
   parameter int STAGES   = 3,
   parameter int DATA_TAP = 0
) (
   input  logic clk,
   input  logic rst,
   input  tag_t tag_in,
   output logic data_vld,
   output tag_t tag_out,
   output logic empty
);

   tag_t [STAGES-1:0] pipe;

   always_ff @(posedge clk) begin
      if (rst) pipe <= '0;
      else     pipe <= {pipe[STAGES-2:0], tag_in};
   end

   always_comb begin
      empty = 1'b1;
      for (int i = 0; i < STAGES; i++)
         if (pipe[i].valid) empty = 1'b0;
   end

   // Tap aligned with the memory read data, gates the pixel stream.
   assign data_vld = pipe[DATA_TAP].valid;
   assign tag_out  = pipe[STAGES-1];

endmodule

// File: rtl/linebuffer_2x2_ctrl.sv
// Frame sequencer: streams a square int4 map into the 2x2 line buffer and tags pooling windows.
module linebuffer_2x2_ctrl
   import lb_ctrl_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int RD_LAT = 1
) (
   input logic                  clk,
   input logic                  rst,
   linebuffer_2x2_ctrl_if.master bus
);

   localparam int STAGES = RD_LAT + 2;

   state_t            state, state_n;
   logic [2:0]        sel, sel_n;
   logic [7:0]        wm1, wm1_n;
   logic [7:0]        row, row_n;
   logic [7:0]        col, col_n;
   logic [ADDR_W-1:0] addr, addr_n;
   logic              err_q, err_n;
   logic [3:0]        pix_q;
   tag_t              tag_in, tag_out;
   logic              data_vld, pipe_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sel   <= '0;
         wm1   <= '0;
         row   <= '0;
         col   <= '0;
         addr  <= '0;
         err_q <= 1'b0;
         pix_q <= '0;
      end else begin
         state <= state_n;
         sel   <= sel_n;
         wm1   <= wm1_n;
         row   <= row_n;
         col   <= col_n;
         addr  <= addr_n;
         err_q <= err_n;
         pix_q <= data_vld ? bus.rd_data : 4'd0;
      end
   end

   always_comb begin
      state_n = state;
      sel_n   = sel;
      wm1_n   = wm1;
      row_n   = row;
      col_n   = col;
      addr_n  = addr;
      err_n   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.cfg_sel <= SEL_MAX) begin
                  sel_n   = bus.cfg_sel;
                  wm1_n   = width_of(bus.cfg_sel) - 8'd1;
                  row_n   = '0;
                  col_n   = '0;
                  addr_n  = '0;
                  state_n = READ;
               end else begin
                  err_n = 1'b1;
               end
            end
         end
         READ: begin
            // Address stays on the last pixel once the frame is fully issued.
            if (row == wm1 && col == wm1) begin
               state_n = FLUSH;
            end else begin
               addr_n = addr + 1'b1;
               if (col == wm1) begin
                  col_n = '0;
                  row_n = row + 8'd1;
               end else begin
                  col_n = col + 8'd1;
               end
            end
         end
         FLUSH: begin
            if (pipe_empty) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign tag_in = {state == READ, row, col};

   lb_tag_pipe #(.STAGES(STAGES), .DATA_TAP(RD_LAT - 1)) u_tag_pipe (
      .clk      (clk),
      .rst      (rst),
      .tag_in   (tag_in),
      .data_vld (data_vld),
      .tag_out  (tag_out),
      .empty    (pipe_empty)
   );

   assign bus.busy    = (state != IDLE);
   assign bus.rd_en   = (state == READ);
   assign bus.done    = (state == FLUSH) && pipe_empty;
   assign bus.err     = err_q;
   assign bus.rd_addr = addr;
   assign bus.lb_sel  = sel;
   assign bus.lb_pix  = pix_q;

   // Only odd row/odd col windows are stride-2 pool positions; this also drops row-wrap windows.
   assign bus.win_valid = tag_out.valid & tag_out.row[0] & tag_out.col[0];
   assign bus.win_row   = tag_out.row[7:1];
   assign bus.win_col   = tag_out.col[7:1];
   assign bus.win_data  = bus.lb_win;

endmodule

// File: tb/tb_linebuffer_2x2_ctrl.sv
// Directed bench for linebuffer_2x2_ctrl with a 1-cycle memory and a 2x2 line-buffer model.
module tb_linebuffer_2x2_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   linebuffer_2x2_ctrl_if #(.ADDR_W(16)) bus();

   linebuffer_2x2_ctrl #(.ADDR_W(16), .RD_LAT(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int tb_w(input logic [2:0] s);
      case (s)
         3'd0: return 8;
         3'd1: return 14;
         3'd2: return 28;
         3'd3: return 56;
         3'd4: return 112;
         3'd5: return 224;
         default: return 8;
      endcase
   endfunction

   // Memory: pixel = addr[3:0]; junk when not read so ungated lb_pix shows up.
   logic [3:0] mem_q = 4'hF;
   always @(posedge clk) mem_q <= bus.rd_en ? bus.rd_addr[3:0] : 4'hF;
   assign bus.rd_data = mem_q;

   // Line buffer: window {br, bl, tr, tl} registered from lb_pix.
   logic [3:0]  sr [0:224];
   logic [15:0] win_q = '0;
   always @(posedge clk) begin
      if (rst) begin
         win_q <= '0;
         for (int i = 0; i <= 224; i++) sr[i] <= '0;
      end else begin
         win_q <= {bus.lb_pix, sr[0], sr[tb_w(bus.lb_sel)-1], sr[tb_w(bus.lb_sel)]};
         for (int i = 224; i > 0; i--) sr[i] <= sr[i-1];
         sr[0] <= bus.lb_pix;
      end
   end
   assign bus.lb_win = win_q;

   // Event recorder
   int n_win, n_rd, n_done, n_err, n_busy, idle_pix, sel_chg;
   int first_rd, first_win, last_win, last_rd, done_cyc, last_addr;
   logic [2:0] sel0;
   int wr_q[$], wc_q[$];
   logic [15:0] wd_q[$];

   task automatic clr_mon();
      n_win = 0; n_rd = 0; n_done = 0; n_err = 0; n_busy = 0; idle_pix = 0; sel_chg = 0;
      first_rd = -1; first_win = -1; last_win = -1; last_rd = -1; done_cyc = -1; last_addr = -1;
      sel0 = '0;
      wr_q.delete(); wc_q.delete(); wd_q.delete();
   endtask

   always @(negedge clk) begin
      if (bus.win_valid) begin
         if (n_win == 0) first_win = cyc;
         last_win = cyc;
         n_win++;
         wr_q.push_back(int'(bus.win_row));
         wc_q.push_back(int'(bus.win_col));
         wd_q.push_back(bus.win_data);
      end
      if (bus.rd_en) begin
         if (n_rd == 0) first_rd = cyc;
         last_rd = cyc;
         last_addr = int'(bus.rd_addr);
         n_rd++;
      end
      if (bus.busy) begin
         if (n_busy == 0) sel0 = bus.lb_sel;
         else if (bus.lb_sel != sel0) sel_chg++;
         n_busy++;
      end
      if (bus.done) begin n_done++; done_cyc = cyc; end
      if (bus.err) n_err++;
      if (!bus.busy && bus.lb_pix != 4'd0) idle_pix++;
   end

   task automatic start_frame(input logic [2:0] s, output int sc);
      @(negedge clk);
      bus.cfg_sel = s;
      bus.start   = 1'b1;
      sc = cyc;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim; i++) begin
         @(negedge clk);
         if (bus.done) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.start = 1'b0; bus.cfg_sel = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
      checks++; if (bus.done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b want=0", bus.done); end
      checks++; if (bus.err !== 1'b0)       begin errors++; $display("FAIL reset_err got=%b want=0", bus.err); end
      checks++; if (bus.rd_en !== 1'b0)     begin errors++; $display("FAIL reset_rd_en got=%b want=0", bus.rd_en); end
      checks++; if (bus.rd_addr !== 16'd0)  begin errors++; $display("FAIL reset_rd_addr got=%0d want=0", bus.rd_addr); end
      checks++; if (bus.lb_sel !== 3'd0)    begin errors++; $display("FAIL reset_lb_sel got=%0d want=0", bus.lb_sel); end
      checks++; if (bus.lb_pix !== 4'd0)    begin errors++; $display("FAIL reset_lb_pix got=%0d want=0", bus.lb_pix); end
      checks++; if (bus.win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid got=%b want=0", bus.win_valid); end
      checks++; if (bus.win_row !== 7'd0 || bus.win_col !== 7'd0)
         begin errors++; $display("FAIL reset_win_pos got=%0d,%0d want=0,0", bus.win_row, bus.win_col); end
   endtask

   task automatic test_frame(input logic [2:0] s, input string nm);
      int sc, w, nw, a;
      bit ok;
      logic [15:0] exp;
      w  = tb_w(s);
      nw = (w / 2) * (w / 2);
      clr_mon();
      start_frame(s, sc);
      wait_done(w * w + 50, ok);
      repeat (2) @(negedge clk);
      checks++; if (!ok) begin errors++; $display("FAIL %s done_timeout got=none want=done", nm); end
      checks++; if (n_win != nw) begin errors++; $display("FAIL %s win_count got=%0d want=%0d", nm, n_win, nw); end
      checks++; if (n_done != 1) begin errors++; $display("FAIL %s done_count got=%0d want=1", nm, n_done); end
      checks++; if (first_rd != sc + 1) begin errors++; $display("FAIL %s first_rd got=%0d want=%0d", nm, first_rd, sc + 1); end
      checks++; if (first_win != first_rd + w + 4) begin errors++; $display("FAIL %s first_win got=%0d want=%0d", nm, first_win, first_rd + w + 4); end
      checks++; if (done_cyc != last_win + 1) begin errors++; $display("FAIL %s done_after_win got=%0d want=%0d", nm, done_cyc, last_win + 1); end
      checks++; if (done_cyc != last_rd + 4) begin errors++; $display("FAIL %s done_after_rd got=%0d want=%0d", nm, done_cyc, last_rd + 4); end
      checks++; if (last_addr != w * w - 1) begin errors++; $display("FAIL %s last_addr got=%0d want=%0d", nm, last_addr, w * w - 1); end
      checks++; if (n_rd != w * w) begin errors++; $display("FAIL %s rd_count got=%0d want=%0d", nm, n_rd, w * w); end
      checks++; if (sel0 != s || sel_chg != 0) begin errors++; $display("FAIL %s lb_sel got=%0d chg=%0d want=%0d", nm, sel0, sel_chg, s); end
      checks++; if (idle_pix != 0) begin errors++; $display("FAIL %s idle_lb_pix got=%0d want=0", nm, idle_pix); end
      for (int k = 0; k < nw && k < n_win; k++) begin
         a   = (2 * (k / (w / 2)) + 1) * w + 2 * (k % (w / 2)) + 1;
         exp = {4'(a), 4'(a - 1), 4'(a - w), 4'(a - w - 1)};
         checks++;
         if (wr_q[k] != k / (w / 2) || wc_q[k] != k % (w / 2) || wd_q[k] !== exp) begin
            errors++;
            $display("FAIL %s win%0d got=(%0d,%0d,%h) want=(%0d,%0d,%h)", nm, k,
                     wr_q[k], wc_q[k], wd_q[k], k / (w / 2), k % (w / 2), exp);
         end
      end
   endtask

   task automatic test_illegal();
      int sc;
      clr_mon();
      start_frame(3'd6, sc);
      repeat (5) @(negedge clk);
      checks++; if (n_err != 1) begin errors++; $display("FAIL illegal6_err got=%0d want=1", n_err); end
      checks++; if (n_busy != 0 || n_rd != 0) begin errors++; $display("FAIL illegal6_idle got busy=%0d rd=%0d want=0,0", n_busy, n_rd); end
      start_frame(3'd7, sc);
      repeat (5) @(negedge clk);
      checks++; if (n_err != 2) begin errors++; $display("FAIL illegal7_err got=%0d want=2", n_err); end
      checks++; if (n_busy != 0 || n_rd != 0) begin errors++; $display("FAIL illegal7_idle got busy=%0d rd=%0d want=0,0", n_busy, n_rd); end
   endtask

   task automatic test_mid_start();
      int sc, sd;
      bit ok;
      clr_mon();
      start_frame(3'd0, sc);
      repeat (10) @(negedge clk);
      start_frame(3'd2, sd);
      wait_done(200, ok);
      repeat (3) @(negedge clk);
      checks++; if (!ok) begin errors++; $display("FAIL mid_start done_timeout got=none want=done"); end
      checks++; if (n_win != 16) begin errors++; $display("FAIL mid_start win_count got=%0d want=16", n_win); end
      checks++; if (sel0 != 3'd0 || sel_chg != 0) begin errors++; $display("FAIL mid_start lb_sel got=%0d chg=%0d want=0", sel0, sel_chg); end
      checks++; if (n_rd != 64 || n_done != 1) begin errors++; $display("FAIL mid_start rd/done got=%0d/%0d want=64/1", n_rd, n_done); end
      checks++; if (n_err != 0) begin errors++; $display("FAIL mid_start err got=%0d want=0", n_err); end
   endtask

   task automatic test_rst_mid();
      int sc;
      bit hit;
      clr_mon();
      start_frame(3'd0, sc);
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (bus.rd_en && bus.rd_addr == 16'd40) begin hit = 1'b1; break; end
         @(negedge clk);
      end
      checks++; if (!hit) begin errors++; $display("FAIL rst_mid read40_timeout got=none want=read40"); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0)
         begin errors++; $display("FAIL rst_mid ctrl got busy=%b rd_en=%b done=%b err=%b want=0", bus.busy, bus.rd_en, bus.done, bus.err); end
      checks++; if (bus.rd_addr !== 16'd0 || bus.lb_pix !== 4'd0 || bus.lb_sel !== 3'd0)
         begin errors++; $display("FAIL rst_mid data got addr=%0d pix=%0d sel=%0d want=0", bus.rd_addr, bus.lb_pix, bus.lb_sel); end
      checks++; if (bus.win_valid !== 1'b0 || bus.win_row !== 7'd0 || bus.win_col !== 7'd0 || bus.win_data !== 16'd0)
         begin errors++; $display("FAIL rst_mid win got v=%b r=%0d c=%0d d=%h want=0", bus.win_valid, bus.win_row, bus.win_col, bus.win_data); end
      clr_mon();
      repeat (20) @(negedge clk);
      checks++; if (n_win != 0 || n_done != 0 || n_busy != 0)
         begin errors++; $display("FAIL rst_mid after got win=%0d done=%0d busy=%0d want=0", n_win, n_done, n_busy); end
      test_frame(3'd0, "post_rst");
   endtask

   task automatic test_back_to_back();
      int sc, sc2;
      bit ok;
      logic [15:0] wd1[$];
      clr_mon();
      start_frame(3'd0, sc);
      wait_done(200, ok);
      checks++; if (!ok) begin errors++; $display("FAIL b2b first_done_timeout got=none want=done"); end
      bus.cfg_sel = 3'd0;
      bus.start   = 1'b1;
      wd1 = wd_q;
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b done_cycle_start got busy=%b want=0", bus.busy); end
      clr_mon();
      sc2 = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b second_start got busy=%b want=1", bus.busy); end
      wait_done(200, ok);
      repeat (2) @(negedge clk);
      checks++; if (!ok) begin errors++; $display("FAIL b2b second_done_timeout got=none want=done"); end
      checks++; if (wd1.size() != 16 || n_win != 16) begin errors++; $display("FAIL b2b win_count got=%0d/%0d want=16/16", wd1.size(), n_win); end
      checks++; if (first_rd != sc2 + 1) begin errors++; $display("FAIL b2b first_rd got=%0d want=%0d", first_rd, sc2 + 1); end
      for (int k = 0; k < 16 && k < n_win && k < wd1.size(); k++) begin
         checks++;
         if (wd_q[k] !== wd1[k]) begin errors++; $display("FAIL b2b win%0d got=%h want=%h", k, wd_q[k], wd1[k]); end
      end
   endtask

   initial begin
      clr_mon();
      test_reset();
      test_frame(3'd0, "w8");
      test_frame(3'd1, "w14");
      test_illegal();
      test_mid_start();
      test_rst_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
